// File: rtl/pc_fetch_responder_if.sv
// Fetch/load bus between the PC requester and the instruction-memory responder.
// Latency: n/a (signal bundle only).
// Backpressure: ready from responder gates req; load port is never backpressured.
interface pc_fetch_responder_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              ready;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;
    logic              rerr;
    logic              increment;
    logic              load_en;
    logic [ADDR_W-1:0] load_addr;
    logic [DATA_W-1:0] load_data;

    modport master (
        output req, addr, load_en, load_addr, load_data,
        input  ready, rvalid, rdata, rerr, increment
    );

    modport slave (
        input  req, addr, load_en, load_addr, load_data,
        output ready, rvalid, rdata, rerr, increment
    );
endinterface

// File: rtl/pc_fetch_responder.sv
// Instruction-memory responder: returns the word at the fetch PC and pulses increment; loadable store.
// Latency: LAT rising edges from accept to the one-cycle rvalid/increment pulse.
// Backpressure: ready low while a fetch waits; req during !ready is dropped. Optional PC_FETCH_COUNT_EN adds fetch_count.
module pc_fetch_responder #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 256,
    parameter int LAT    = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    pc_fetch_responder_if.slave  bus
`ifdef PC_FETCH_COUNT_EN
    ,
    output logic [31:0]          fetch_count
`endif
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Counter preload: WAIT lasts LAT-1 cycles, so it counts down from LAT-2.
    localparam logic [1:0] CNT_INIT = (LAT > 1) ? 2'(LAT - 2) : 2'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] cap_dat_q, cap_dat_d;
    logic              cap_err_q, cap_err_d;
    logic              rvalid_q, rvalid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rerr_q, rerr_d;

    logic              ready;
    logic              accept;
    logic              rd_hit;
    logic              wr_hit;

    assign ready  = (state_q == IDLE) || (state_q == RESP);
    assign accept = bus.req && ready;
    assign rd_hit = (32'(bus.addr) < 32'(DEPTH));
    assign wr_hit = (32'(bus.load_addr) < 32'(DEPTH));

    // Program store: written in every state, never reset; out-of-range writes dropped.
    always_ff @(posedge clk) begin
        if (bus.load_en && wr_hit) begin
            mem[bus.load_addr[IDX_W-1:0]] <= bus.load_data;
        end
    end

    // Next state, capture of the fetched word and response generation.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cap_dat_d = cap_dat_q;
        cap_err_d = cap_err_q;
        rvalid_d  = 1'b0;
        rdata_d   = rdata_q;
        rerr_d    = rerr_q;

        case (state_q)
            IDLE: ;
            WAIT: begin
                if (cnt_q == 2'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            RESP: begin
                state_d  = IDLE;
                rvalid_d = 1'b1;
                rdata_d  = cap_dat_q;
                rerr_d   = cap_err_q;
            end
            default: state_d = IDLE;
        endcase

        // Array read is combinational here and registered at the accept edge,
        // so a same-edge write to the same word is not seen (read-old).
        if (accept) begin
            cap_dat_d = rd_hit ? mem[bus.addr[IDX_W-1:0]] : '0;
            cap_err_d = !rd_hit;
            state_d   = (LAT == 1) ? RESP : WAIT;
            cnt_d     = CNT_INIT;
        end
    end

    // Control and response registers; reset aborts any in-flight fetch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= 2'd0;
            cap_dat_q <= '0;
            cap_err_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rerr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cap_dat_q <= cap_dat_d;
            cap_err_q <= cap_err_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rerr_q    <= rerr_d;
        end
    end

    assign bus.ready     = ready;
    assign bus.rvalid    = rvalid_q;
    assign bus.increment = rvalid_q;
    assign bus.rdata     = rdata_q;
    assign bus.rerr      = rerr_q;

`ifdef PC_FETCH_COUNT_EN
    logic [31:0] fetch_count_q, fetch_count_d;

    // Counts every response, error or not; wraps naturally.
    always_comb begin
        fetch_count_d = fetch_count_q + 32'(rvalid_d);
    end

    // Response counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_count_q <= 32'd0;
        end else begin
            fetch_count_q <= fetch_count_d;
        end
    end

    assign fetch_count = fetch_count_q;
`endif

endmodule

// File: tb/tb_pc_fetch_responder.sv
// Bench for pc_fetch_responder: LAT=2 instance against a queue-based reference model,
// plus a LAT=3 instance for directed mid-fetch reset checks.
module tb_pc_fetch_responder;

    localparam int LAT1 = 2;
    localparam int LAT2 = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pc_fetch_responder_if #(.ADDR_W(16), .DATA_W(16)) b1 ();
    pc_fetch_responder_if #(.ADDR_W(16), .DATA_W(16)) b2 ();

`ifdef PC_FETCH_COUNT_EN
    logic [31:0] fc1, fc2;
`endif

    pc_fetch_responder #(.ADDR_W(16), .DATA_W(16), .DEPTH(256), .LAT(LAT1)) u_dut1 (
        .clk   (clk),
        .reset (rst),
        .bus   (b1)
`ifdef PC_FETCH_COUNT_EN
        ,
        .fetch_count (fc1)
`endif
    );

    pc_fetch_responder #(.ADDR_W(16), .DATA_W(16), .DEPTH(256), .LAT(LAT2)) u_dut2 (
        .clk   (clk),
        .reset (rst),
        .bus   (b2)
`ifdef PC_FETCH_COUNT_EN
        ,
        .fetch_count (fc2)
`endif
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a fetch accepted at edge e answers at edge e+LAT; the block
    // is busy (not ready) for the edges in between.
    typedef struct {
        int          at_edge;
        logic [15:0] dat;
        logic        err;
    } resp_t;

    logic [15:0] mdl_mem [256];
    resp_t       pend [$];
    int          edge_n   = 0;
    int          last_acc = -100;
    logic [15:0] exp_rdata = '0;
    logic        exp_rerr  = 1'b0;
    int          exp_cnt   = 0;
    bit          acc;

    task automatic cycle(input logic rq, input logic [15:0] a, input logic le,
                         input logic [15:0] la, input logic [15:0] ld);
        resp_t r;
        logic  exp_rv;
        @(negedge clk);
        b1.req = rq; b1.addr = a; b1.load_en = le; b1.load_addr = la; b1.load_data = ld;
        #1;
        chk("ready", b1.ready, 32'(edge_n >= last_acc + LAT1));
        acc = rq && (edge_n >= last_acc + LAT1);
        if (acc) begin
            r.at_edge = edge_n + LAT1;
            r.err     = (a >= 16'd256);
            r.dat     = r.err ? 16'h0000 : mdl_mem[a[7:0]];
            pend.push_back(r);
            last_acc = edge_n;
        end
        if (le && la < 16'd256) mdl_mem[la[7:0]] = ld;
        @(posedge clk); #1;
        exp_rv = (pend.size() > 0) && (pend[0].at_edge == edge_n);
        if (exp_rv) begin
            r = pend.pop_front();
            exp_rdata = r.dat;
            exp_rerr  = r.err;
            exp_cnt++;
        end
        chk("rvalid", b1.rvalid, 32'(exp_rv));
        chk("increment", b1.increment, 32'(exp_rv));
        chk("rdata", b1.rdata, exp_rdata);
        chk("rerr", b1.rerr, exp_rerr);
`ifdef PC_FETCH_COUNT_EN
        chk("fetch_count", fc1, exp_cnt);
`endif
        edge_n++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
    endtask

    // Single fetch that waits until accepted (bounded), then lets it complete.
    task automatic fetch(input logic [15:0] a);
        int guard = 0;
        acc = 1'b0;
        while (!acc && guard < 10) begin
            cycle(1'b1, a, 1'b0, 16'h0, 16'h0);
            guard++;
        end
        if (!acc) chk("fetch_accept_timeout", 0, 1);
        idle(LAT1 + 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        b1.req = 1'b0; b1.load_en = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_rvalid", b1.rvalid, 0);
        chk("rst_incr", b1.increment, 0);
        chk("rst_rdata", b1.rdata, 0);
        chk("rst_rerr", b1.rerr, 0);
        chk("rst_ready", b1.ready, 1);
`ifdef PC_FETCH_COUNT_EN
        chk("rst_count", fc1, 0);
`endif
        pend.delete();
        last_acc  = edge_n - 100;
        exp_rdata = '0;
        exp_rerr  = 1'b0;
        exp_cnt   = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        b1.req = 0; b1.addr = 0; b1.load_en = 0; b1.load_addr = 0; b1.load_data = 0;
        b2.req = 0; b2.addr = 0; b2.load_en = 0; b2.load_addr = 0; b2.load_data = 0;
        #1;
        chk("init_rvalid", b1.rvalid, 0);
        chk("init_rdata", b1.rdata, 0);
        chk("init_ready", b1.ready, 1);
        chk("init2_ready", b2.ready, 1);
        @(negedge clk); rst = 1'b0;

        // ---- LAT=3 instance: normal fetch, then reset one cycle after accept ----
        @(negedge clk);
        b2.load_en = 1; b2.load_addr = 16'h0005; b2.load_data = 16'h5A5A;
        @(negedge clk);
        b2.load_en = 0; b2.req = 1; b2.addr = 16'h0005;
        @(posedge clk); #1;
        chk("l3_busy", b2.ready, 0);
        chk("l3_rv0", b2.rvalid, 0);
        @(negedge clk); b2.req = 0;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            chk("l3_rv_timing", b2.rvalid, 32'(k == 3));
        end
        chk("l3_rdata", b2.rdata, 16'h5A5A);
        @(posedge clk); #1;
        chk("l3_rv_once", b2.rvalid, 0);
        chk("l3_hold", b2.rdata, 16'h5A5A);
        @(negedge clk); b2.req = 1;
        @(posedge clk); #1;
        @(negedge clk); b2.req = 0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("l3_abort_rv", b2.rvalid, 0);
        chk("l3_abort_rdata", b2.rdata, 0);
        chk("l3_abort_rerr", b2.rerr, 0);
        chk("l3_abort_ready", b2.ready, 1);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            chk("l3_no_rv", b2.rvalid, 0);
        end
        @(negedge clk); rst = 1'b0;
        #1;
        chk("l3_post_ready", b2.ready, 1);
        b2.req = 1;
        @(posedge clk); #1;
        @(negedge clk); b2.req = 0;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            chk("l3_refetch_rv", b2.rvalid, 32'(k == 3));
        end
        chk("l3_refetch_rdata", b2.rdata, 16'h5A5A);

        // ---- LAT=2 instance against the model ----
        do_reset();
        for (int i = 0; i < 256; i++) cycle(1'b0, 16'h0, 1'b1, 16'(i), 16'($urandom));
        cycle(1'b0, 16'h0, 1'b1, 16'h0000, 16'h1111);
        cycle(1'b0, 16'h0, 1'b1, 16'h0001, 16'h2222);
        cycle(1'b0, 16'h0, 1'b1, 16'h0002, 16'h3333);
        cycle(1'b0, 16'h0, 1'b1, 16'h0003, 16'h4444);
        cycle(1'b0, 16'h0, 1'b1, 16'h0010, 16'hA5A5);
        cycle(1'b0, 16'h0, 1'b1, 16'h0020, 16'h1234);
        cycle(1'b0, 16'h0, 1'b1, 16'h0120, 16'hDEAD);   // dropped, out of range

        fetch(16'h0010);
        chk("a5a5", b1.rdata, 16'hA5A5);
        chk("a5a5_err", b1.rerr, 0);

        // Back-to-back: req held, addr advances on each accept.
        begin
            int idx = 0;
            int guard = 0;
            while (idx < 4 && guard < 20) begin
                cycle(1'b1, 16'(idx), 1'b0, 16'h0, 16'h0);
                if (acc) idx++;
                guard++;
            end
            chk("b2b_accepts", idx, 4);
            chk("b2b_cycles", guard, 7);
            idle(3);
            chk("b2b_last", b1.rdata, 16'h4444);
        end

        fetch(16'h0100);
        chk("oor_err", b1.rerr, 1);
        chk("oor_dat", b1.rdata, 0);
        fetch(16'h0003);
        chk("after_oor_err", b1.rerr, 0);
        chk("after_oor_dat", b1.rdata, 16'h4444);

        // Same-edge write and fetch: read-old.
        cycle(1'b1, 16'h0020, 1'b1, 16'h0020, 16'hBEEF);
        chk("rold_acc", 32'(acc), 1);
        idle(LAT1 + 1);
        chk("read_old", b1.rdata, 16'h1234);
        fetch(16'h0020);
        chk("read_new", b1.rdata, 16'hBEEF);

        // Reset one cycle after accept on LAT=2: no response for it.
        cycle(1'b1, 16'h0001, 1'b0, 16'h0, 16'h0);
        idle(1);
        do_reset();
        idle(3);
        fetch(16'h0002);
        chk("post_rst_fetch", b1.rdata, 16'h3333);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            logic [15:0] a, la;
            a  = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(256, 65535)) : 16'($urandom_range(0, 255));
            la = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(256, 65535)) : 16'($urandom_range(0, 255));
            cycle($urandom_range(0, 3) != 0, a, $urandom_range(0, 2) == 0, la, 16'($urandom));
        end
        idle(4);

`ifdef PC_FETCH_COUNT_EN
        do_reset();
        for (int i = 0; i < 5; i++) fetch((i == 2) ? 16'h0300 : 16'(i));
        chk("count5", fc1, 5);
        do_reset();
        chk("count_rst", fc1, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_fetch_responder.md
Name: pc_fetch_responder

Overview:
- Instruction-memory responder sitting at the far end of the program-counter fetch interface.
- Accepts a fetch request carrying the PC address and returns the instruction word after a fixed latency.
- Generates the one-cycle `increment` pulse that advances the PC.
- Holds a loadable program store written by the boot loader port.

Parameters:
- ADDR_W, 16, width of fetch/load address (matches PC width).
- DATA_W, 16, instruction word width.
- DEPTH, 256, number of implemented words; addresses >= DEPTH are out of range.
- LAT, 2, fetch latency in clock edges, legal range 1..4.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  1  fetch request; sampled only when the block is ready.
- addr  in  ADDR_W  fetch address (PC value); sampled with an accepted req.
- ready  out  1  block can accept req this cycle.
- rvalid  out  1  one-cycle pulse; rdata/rerr valid.
- rdata  out  DATA_W  fetched instruction.
- rerr  out  1  accepted address was >= DEPTH; qualified by rvalid.
- increment  out  1  equals rvalid; drives PC increment.
- load_en  in  1  program-store write strobe.
- load_addr  in  ADDR_W  write address; writes to addresses >= DEPTH are dropped.
- load_data  in  DATA_W  write data.

Behaviour:
- Reset (async, active-high): state=IDLE, rvalid=0, increment=0, rdata=0, rerr=0, ready=1, internal counter=0. Program store contents are not reset.
- Reset asserted mid-fetch aborts the fetch. No rvalid is produced for it, and ready is 1 after reset deasserts.
- States: IDLE, WAIT, RESP.
- ready = (state==IDLE) or (state==RESP). Combinational from the registered state.
- Accept: req=1 and ready=1 at rising edge T.
  - On accept, capture the array word at addr, or 0 with rerr=1 if addr >= DEPTH.
  - The captured word is the pre-write value if load_en hits the same address at edge T (read-old).
- Transitions:
  - Accept with LAT=1: go to RESP.
  - Accept with LAT>1: go to WAIT, counter=LAT-2.
  - WAIT: if counter==0, go to RESP; else decrement.
  - RESP without accept: go to IDLE.
  - RESP with accept: back-to-back fetch, follows the same accept rule.
- Latency: rvalid=1 for exactly one cycle following edge T+LAT. rdata/rerr are held from that edge until the next response.
- Throughput: one fetch per LAT cycles maximum.
- req while ready=0 is ignored (not queued); the requester must hold req.
- addr changes after accept have no effect on the in-flight fetch.
- load_en is accepted in every state. A write after edge T does not alter the in-flight captured word.
- increment is the same register as rvalid.

Optional Feature:
- Macro: PC_FETCH_COUNT_EN.
- Defined:
  - Adds output fetch_count [31:0], reset to 0.
  - Increments on every rvalid pulse, including rerr responses.
  - Wraps 0xFFFFFFFF to 0.
- Undefined: no fetch_count port and no counter logic. All other behaviour is identical.

Test Plan:
- LAT=2; load 0x0010<-0xA5A5. req=1, addr=0x0010 accepted at edge T -> rvalid=1, rdata=0xA5A5, rerr=0, increment=1 after edge T+2, for one cycle only.
- req held high continuously, addresses 0..3 preloaded with 0x1111/0x2222/0x3333/0x4444, addr advancing on each accept -> four rvalid pulses spaced 2 cycles apart with those words in order.
- addr=0x0100 (DEPTH=256) -> rvalid=1, rerr=1, rdata=0x0000. A subsequent fetch of a valid address returns rerr=0.
- load_en to 0x0020 with 0xBEEF at the same edge a fetch of 0x0020 is accepted (old value 0x1234) -> rdata=0x1234. The next fetch of 0x0020 returns 0xBEEF.
- reset asserted one cycle after accept (LAT=3) -> outputs go to 0 immediately, with no rvalid. After release, ready=1 and a new fetch completes normally.
- With PC_FETCH_COUNT_EN: 5 fetches (one out of range) -> fetch_count=5. Reset -> 0.
